// File: rtl/pre_input_pkg.sv
// Shared constants and state type for the ibuf pre-loader: one polynomial set is
// 3072 ibuf words of eight coefficient lanes each.
package pre_input_pkg;

  localparam logic [11:0] IBUF_LAST_ADDR = 12'hbff;
  localparam int          IBUF_LANES     = 8;
  localparam int          IBUF_LAST_BEAT = 24575;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/ibuf_lane_packer.sv
// Gathers eight consecutive stream beats into one ibuf word; lane k holds beat k
// of the group. The word output already includes the beat being accepted this cycle.
module ibuf_lane_packer
  import pre_input_pkg::*;
#(
  parameter int DATA_WIDTH = 39
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             beat_en,
  input  logic [DATA_WIDTH-1:0]            beat_data,
  output logic [2:0]                       lane,
  output logic                             word_complete,
  output logic [IBUF_LANES*DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] lane_q [IBUF_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      for (int k = 0; k < IBUF_LANES; k++) lane_q[k] <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (beat_en) begin
      lane_q[lane] <= beat_data;
      lane         <= lane + 3'd1;
    end
  end

  // Bypassing the current beat lets the top capture a full word on the lane-7
  // handshake itself, so the next group may start filling immediately.
  always_comb begin
    word = '0;
    for (int k = 0; k < IBUF_LANES; k++) begin
      word[k*DATA_WIDTH +: DATA_WIDTH] = (beat_en && lane == 3'(k)) ? beat_data : lane_q[k];
    end
  end

  assign word_complete = beat_en && (lane == 3'(IBUF_LANES - 1));

endmodule

// File: rtl/pre_input_loader.sv
// AXI4-Stream to ibuf loader: packs 24576 beats into 3072 ibuf writes, then waits
// for the transposer. Define PRE_INPUT_LOADER_RANGE_CHECK_EN to add o_err_range.
module pre_input_loader
  import pre_input_pkg::*;
#(
  parameter int DATA_WIDTH = 39
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [63:0]                      s_axis_tdata,
  input  logic                             s_axis_tlast,
  output logic                             o_ibuf_reset,
  output logic                             o_ibuf_wren,
  output logic [11:0]                      o_ibuf_addr,
  output logic [IBUF_LANES*DATA_WIDTH-1:0] o_ibuf_data,
  input  logic                             i_ibuf_done,
  output logic                             o_busy,
  output logic                             o_done,
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
  output logic                             o_err_range,
`endif
  output logic                             o_err_last
);

  loader_state_t state_q, state_d;

  logic [11:0]                      addr_q;
  logic [2:0]                       lane;
  logic                             word_complete;
  logic [IBUF_LANES*DATA_WIDTH-1:0] word;
  logic                             handshake;
  logic                             start_load;
  logic                             final_beat;

  assign s_axis_tready = (state_q == LOAD);
  assign o_busy        = (state_q != IDLE);
  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign start_load    = (state_q == IDLE) && i_start;
  assign o_ibuf_reset  = start_load;
  assign final_beat    = handshake && ({addr_q, lane} == 15'(IBUF_LAST_BEAT));

  ibuf_lane_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (start_load),
    .beat_en       (handshake),
    .beat_data     (s_axis_tdata[DATA_WIDTH-1:0]),
    .lane          (lane),
    .word_complete (word_complete),
    .word          (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_start) state_d = LOAD;
      LOAD:      if (word_complete && addr_q == IBUF_LAST_ADDR) state_d = WAIT_DONE;
      WAIT_DONE: if (i_ibuf_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The address counter parks on the last address so it can never run past the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      o_ibuf_wren <= 1'b0;
      o_ibuf_addr <= '0;
      o_ibuf_data <= '0;
    end else begin
      o_ibuf_wren <= word_complete;
      if (start_load) begin
        addr_q <= '0;
      end else if (word_complete) begin
        o_ibuf_addr <= addr_q;
        o_ibuf_data <= word;
        if (addr_q != IBUF_LAST_ADDR) addr_q <= addr_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_done     <= 1'b0;
      o_err_last <= 1'b0;
    end else begin
      o_done <= (state_q == WAIT_DONE) && i_ibuf_done;
      if (start_load) o_err_last <= 1'b0;
      else if (handshake && (s_axis_tlast != final_beat)) o_err_last <= 1'b1;
    end
  end

`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
  logic upper_nonzero;

  if (DATA_WIDTH < 64) begin : g_upper
    assign upper_nonzero = |s_axis_tdata[63:DATA_WIDTH];
  end else begin : g_full
    assign upper_nonzero = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          o_err_range <= 1'b0;
    else if (start_load)                 o_err_range <= 1'b0;
    else if (handshake && upper_nonzero) o_err_range <= 1'b1;
  end
`else
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
`endif

endmodule

// File: tb/tb_pre_input_loader.sv
// Self-checking bench for pre_input_loader: control table, three stream loads
// against a beat-queue scoreboard, mid-load reset and error flag sequences.
module tb_pre_input_loader;

  localparam int DW     = 39;
  localparam int WRITES = 3072;
  localparam int BEATS  = 24576;

  typedef struct {
    logic start;
    logic ibuf_done;
    logic exp_ibuf_reset;
    logic exp_tready;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [63:0]     s_axis_tdata;
  logic            s_axis_tlast;
  logic            o_ibuf_reset;
  logic            o_ibuf_wren;
  logic [11:0]     o_ibuf_addr;
  logic [8*DW-1:0] o_ibuf_data;
  logic            i_ibuf_done;
  logic            o_busy;
  logic            o_done;
  logic            o_err_last;
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
  logic            o_err_range;
`endif

  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;
  int          reset_pulses = 0;
  int          done_pulses = 0;
  bit          abort = 1'b0;
  logic        prev_wren = 1'b0;
  logic [63:0] beat_q[$];
  logic [63:0] popped;
  logic [8*DW-1:0] exp_word;
  logic [63:0] mask = (64'd1 << DW) - 64'd1;
  vec_t        vecs[6];

  pre_input_loader #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .o_ibuf_reset  (o_ibuf_reset),
    .o_ibuf_wren   (o_ibuf_wren),
    .o_ibuf_addr   (o_ibuf_addr),
    .o_ibuf_data   (o_ibuf_data),
    .i_ibuf_done   (i_ibuf_done),
    .o_busy        (o_busy),
    .o_done        (o_done),
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
    .o_err_range   (o_err_range),
`endif
    .o_err_last    (o_err_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    step();
    i_start       = v.start;
    i_ibuf_done   = v.ibuf_done;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("ctl%0d_ibuf_reset", idx), o_ibuf_reset, v.exp_ibuf_reset);
    checkOutput($sformatf("ctl%0d_tready", idx), s_axis_tready, v.exp_tready);
    checkOutput($sformatf("ctl%0d_busy", idx), o_busy, v.exp_busy);
    checkOutput($sformatf("ctl%0d_done", idx), o_done, v.exp_done);
  endtask

  // Offers one beat, randomly withholding tvalid, until the DUT accepts it.
  task automatic sendBeat(input logic [63:0] d, input logic last, input int pct);
    int waited = 0;
    if (abort) return;
    forever begin
      step();
      if ($urandom_range(99) < pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'($urandom);
      end
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        beat_q.push_back(d & mask);
        return;
      end
      waited++;
      if (waited > 200) begin
        checkOutput("beat_accept_timeout", s_axis_tready, 1'b1);
        abort = 1'b1;
        return;
      end
    end
  endtask

  task automatic finishLoad(input logic exp_err);
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    checkOutput("tready_low_after_final", s_axis_tready, 1'b0);
    checkOutput("busy_in_wait_done", o_busy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      @(negedge clk);
      checkOutput("tready_held_low", s_axis_tready, 1'b0);
    end
    step();
    s_axis_tvalid = 1'b0;
    i_ibuf_done   = 1'b1;
    @(negedge clk);
    checkOutput("done_not_early", o_done, 1'b0);
    checkOutput("write_count", wr_count, WRITES);
    checkOutput("beats_left_over", beat_q.size(), 0);
    checkOutput("ibuf_reset_pulses", reset_pulses, 1);
    checkOutput("no_spurious_done", done_pulses, 0);
    checkOutput("err_last_flag", o_err_last, exp_err);
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
    checkOutput("err_range_flag", o_err_range, exp_err);
`endif
    step();
    i_ibuf_done  = 1'b0;
    i_start      = 1'b1;
    wr_count     = 0;
    reset_pulses = 0;
    @(negedge clk);
    checkOutput("done_pulse", o_done, 1'b1);
    checkOutput("idle_in_done_cycle", o_busy, 1'b0);
    checkOutput("start_in_done_cycle", o_ibuf_reset, 1'b1);
    step();
    i_start     = 1'b0;
    done_pulses = 0;
    @(negedge clk);
    checkOutput("done_one_cycle", o_done, 1'b0);
    checkOutput("busy_after_restart", o_busy, 1'b1);
    checkOutput("tready_after_restart", s_axis_tready, 1'b1);
    checkOutput("err_last_cleared", o_err_last, 1'b0);
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
    checkOutput("err_range_cleared", o_err_range, 1'b0);
`endif
  endtask

  // Scoreboard: every write must carry the next eight accepted beats in lane order.
  always @(negedge clk) begin
    if (o_ibuf_wren) begin
      checkOutput("wren_not_back_to_back", prev_wren, 1'b0);
      if (beat_q.size() < 8) begin
        checkOutput("write_has_8_beats", beat_q.size(), 8);
      end else begin
        for (int k = 0; k < 8; k++) begin
          popped = beat_q.pop_front();
          exp_word[k*DW +: DW] = popped[DW-1:0];
        end
        checkOutput("write_addr", o_ibuf_addr, wr_count[11:0]);
        checkOutput("write_data", o_ibuf_data, exp_word);
      end
      wr_count++;
    end
    prev_wren = o_ibuf_wren;
    if (o_ibuf_reset) reset_pulses++;
    if (o_done) done_pulses++;
  end

  initial begin
    logic [63:0] d;

    vecs[0] = '{start: 0, ibuf_done: 0, exp_ibuf_reset: 0, exp_tready: 0, exp_busy: 0, exp_done: 0};
    vecs[1] = '{start: 0, ibuf_done: 1, exp_ibuf_reset: 0, exp_tready: 0, exp_busy: 0, exp_done: 0};
    vecs[2] = '{start: 1, ibuf_done: 0, exp_ibuf_reset: 1, exp_tready: 0, exp_busy: 0, exp_done: 0};
    vecs[3] = '{start: 1, ibuf_done: 1, exp_ibuf_reset: 0, exp_tready: 1, exp_busy: 1, exp_done: 0};
    vecs[4] = '{start: 0, ibuf_done: 1, exp_ibuf_reset: 0, exp_tready: 1, exp_busy: 1, exp_done: 0};
    vecs[5] = '{start: 0, ibuf_done: 0, exp_ibuf_reset: 0, exp_tready: 1, exp_busy: 1, exp_done: 0};

    rst_n         = 1'b0;
    i_start       = 1'b0;
    i_ibuf_done   = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctl_outputs",
                {s_axis_tready, o_ibuf_wren, o_busy, o_done, o_err_last, o_ibuf_reset}, 6'b0);
    checkOutput("reset_addr", o_ibuf_addr, 12'd0);
    checkOutput("reset_data", o_ibuf_data, '0);
    rst_n = 1'b1;

    // Load 1: control table, then back-to-back beats carrying their own index.
    for (int v = 0; v < 6; v++) applyStimulus(vecs[v], v);
    for (int i = 0; i < BEATS; i++) begin
      if (i == 1000) begin
        i_start     = 1'b1;
        i_ibuf_done = 1'b1;
      end
      if (i == 1002) begin
        i_start     = 1'b0;
        i_ibuf_done = 1'b0;
      end
      sendBeat(64'(i), i == BEATS - 1, 100);
    end
    finishLoad(1'b0);

    // Load 2: throttled at 30%, early tlast on beat 100, reset after beat 4999.
    for (int i = 0; i < 5000; i++) begin
      sendBeat(64'(i), i == 100, (i < 1200) ? 30 : 100);
      if (i == 100) begin
        checkOutput("err_last_before_beat100", o_err_last, 1'b0);
        step();
        s_axis_tvalid = 1'b0;
        checkOutput("err_last_after_beat100", o_err_last, 1'b1);
      end
    end
    step();
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    checkOutput("midload_write_count", wr_count, 625);
    checkOutput("midload_reset_pulses", reset_pulses, 1);
    checkOutput("midload_err_last", o_err_last, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ctl_outputs",
                {s_axis_tready, o_ibuf_wren, o_busy, o_done, o_err_last, o_ibuf_reset}, 6'b0);
    checkOutput("midreset_addr", o_ibuf_addr, 12'd0);
    checkOutput("midreset_data", o_ibuf_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat_q.delete();
    wr_count     = 0;
    reset_pulses = 0;
    done_pulses  = 0;

    // Load 3: fresh start, random data at 85% valid, tlast missing on the final beat.
    step();
    i_start = 1'b1;
    @(negedge clk);
    checkOutput("restart_ibuf_reset", o_ibuf_reset, 1'b1);
    step();
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("restart_tready", s_axis_tready, 1'b1);
    for (int i = 0; i < BEATS; i++) begin
      d = {$urandom, $urandom} & mask;
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
      if (i == 10) d[DW] = 1'b1;
`endif
      if (i == BEATS - 1) checkOutput("err_last_before_final", o_err_last, 1'b0);
      sendBeat(d, 1'b0, 85);
`ifdef PRE_INPUT_LOADER_RANGE_CHECK_EN
      if (i == 10) begin
        checkOutput("err_range_before", o_err_range, 1'b0);
        step();
        s_axis_tvalid = 1'b0;
        checkOutput("err_range_after", o_err_range, 1'b1);
      end
`endif
    end
    finishLoad(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
